sdram_req_scheduler: RTL and testbench

SDRAM_REQ_SCHEDULER -- requirements
Module: sdram_req_scheduler

---
 rtl/sdram_sched_pkg.sv | 21 ++
 rtl/sched_grant_select.sv | 33 +++
 rtl/sdram_req_scheduler.sv | 175 +++++++++++++++++
 tb/tb_sdram_req_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM request scheduler.
//   grant_e : owner code driven on o_Grant (0 none, 1 FL, 2 IC, 3 DC)
//   state_e : scheduler FSM states
//   CNT_W   : width of the exported grant counters
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_FL   = 2'd1,
        GNT_IC   = 2'd2,
        GNT_DC   = 2'd3
    } grant_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/sched_grant_select.sv
// Combinational arbitration pick for the SDRAM request scheduler.
//   i_load_done    : flash load complete; while low only FL may win
//   i_*_valid      : raw requests from FL / IC / DC
//   i_last_was_ic  : round-robin history, 1 = IC was served most recently
//   o_pick         : winning requester, GNT_NONE if nothing is eligible
module sched_grant_select
    import sdram_sched_pkg::*;
(
    input  logic   i_load_done,
    input  logic   i_fl_valid,
    input  logic   i_ic_valid,
    input  logic   i_dc_valid,
    input  logic   i_last_was_ic,
    output grant_e o_pick
);

    always_comb begin
        o_pick = GNT_NONE;
        if (i_fl_valid) begin
            // FL is eligible both before and after load, and always outranks IC/DC.
            o_pick = GNT_FL;
        end else if (i_load_done) begin
            if (i_ic_valid && i_dc_valid) begin
                o_pick = i_last_was_ic ? GNT_DC : GNT_IC;
            end else if (i_ic_valid) begin
                o_pick = GNT_IC;
            end else if (i_dc_valid) begin
                o_pick = GNT_DC;
            end
        end
    end

endmodule

// File: rtl/sdram_req_scheduler.sv
// Arbitrates FL / IC / DC burst requests onto a single SDRAM controller port.
//   i_Clk, i_Reset        : clock, synchronous active-high reset
//   i_Load_Done           : gates IC/DC eligibility until flash load is done
//   i_<R>_*               : per-requester request (valid, rd/wr_n, address, write data)
//   o_<R>_*               : per-requester response strobes (gated by grant) and read data
//   o_MEM_* / i_MEM_*     : request to / responses from the SDRAM controller
//   o_Grant               : current owner code
//   o_Grant_Count_IC/DC   : saturating burst-grant counters
// GRANT_CNT_W sets the internal counter width (saturation at all-ones);
// the count ports are always CNT_W bits, zero-extended.
module sdram_req_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 22,
    parameter int GRANT_CNT_W   = CNT_W
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Load_Done,
    input  logic                     i_FL_Valid,
    input  logic                     i_FL_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_FL_Address,
    input  logic [DATA_WIDTH-1:0]    i_FL_Data,
    output logic                     o_FL_Data_Read,
    output logic                     o_FL_Valid,
    output logic                     o_FL_Last,
    output logic [DATA_WIDTH-1:0]    o_FL_Data,
    input  logic                     i_IC_Valid,
    input  logic                     i_IC_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_IC_Address,
    input  logic [DATA_WIDTH-1:0]    i_IC_Data,
    output logic                     o_IC_Data_Read,
    output logic                     o_IC_Valid,
    output logic                     o_IC_Last,
    output logic [DATA_WIDTH-1:0]    o_IC_Data,
    input  logic                     i_DC_Valid,
    input  logic                     i_DC_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_DC_Address,
    input  logic [DATA_WIDTH-1:0]    i_DC_Data,
    output logic                     o_DC_Data_Read,
    output logic                     o_DC_Valid,
    output logic                     o_DC_Last,
    output logic [DATA_WIDTH-1:0]    o_DC_Data,
    output logic                     o_MEM_Valid,
    output logic                     o_MEM_Read_Write_n,
    output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    input  logic                     i_MEM_Data_Read,
    input  logic                     i_MEM_Data_Valid,
    input  logic                     i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
    output logic [1:0]               o_Grant,
    output logic [CNT_W-1:0]         o_Grant_Count_IC,
    output logic [CNT_W-1:0]         o_Grant_Count_DC
);

    state_e                 state_q, state_d;
    grant_e                 grant_q, grant_d;
    logic                   last_ic_q, last_ic_d;
    logic [GRANT_CNT_W-1:0] cnt_ic_q, cnt_ic_d;
    logic [GRANT_CNT_W-1:0] cnt_dc_q, cnt_dc_d;
    grant_e                 pick;
    logic                   burst_act;

    sched_grant_select u_sel (
        .i_load_done   (i_Load_Done),
        .i_fl_valid    (i_FL_Valid),
        .i_ic_valid    (i_IC_Valid),
        .i_dc_valid    (i_DC_Valid),
        .i_last_was_ic (last_ic_q),
        .o_pick        (pick)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_ic_d = last_ic_q;
        cnt_ic_d  = cnt_ic_q;
        cnt_dc_d  = cnt_dc_q;
        case (state_q)
            ST_IDLE: begin
                // i_MEM_Last is ignored here; only a new pick moves us.
                if (pick != GNT_NONE) begin
                    state_d = ST_BURST;
                    grant_d = pick;
                    if (pick == GNT_IC) begin
                        last_ic_d = 1'b1;
                        if (cnt_ic_q != '1) cnt_ic_d = cnt_ic_q + 1'b1;
                    end else if (pick == GNT_DC) begin
                        last_ic_d = 1'b0;
                        if (cnt_dc_q != '1) cnt_dc_d = cnt_dc_q + 1'b1;
                    end
                end
            end
            ST_BURST: begin
                // Requester valids are not looked at: the burst ends only on i_MEM_Last.
                if (i_MEM_Last) begin
                    state_d = ST_IDLE;
                    grant_d = GNT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= GNT_NONE;
            last_ic_q <= 1'b0;      // DC counted as last served, so IC wins the first tie
            cnt_ic_q  <= '0;
            cnt_dc_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_ic_q <= last_ic_d;
            cnt_ic_q  <= cnt_ic_d;
            cnt_dc_q  <= cnt_dc_d;
        end
    end

    // Strobes are also masked in the reset cycle itself so nothing leaks
    // out while a burst is being torn down.
    assign burst_act = (state_q == ST_BURST) && !i_Reset;

    always_comb begin
        o_MEM_Valid        = burst_act;
        o_MEM_Read_Write_n = 1'b0;
        o_MEM_Address      = '0;
        o_MEM_Data         = '0;
        if (burst_act) begin
            case (grant_q)
                GNT_FL: begin
                    o_MEM_Read_Write_n = i_FL_Read_Write_n;
                    o_MEM_Address      = i_FL_Address;
                    o_MEM_Data         = i_FL_Data;
                end
                GNT_IC: begin
                    o_MEM_Read_Write_n = i_IC_Read_Write_n;
                    o_MEM_Address      = i_IC_Address;
                    o_MEM_Data         = i_IC_Data;
                end
                GNT_DC: begin
                    o_MEM_Read_Write_n = i_DC_Read_Write_n;
                    o_MEM_Address      = i_DC_Address;
                    o_MEM_Data         = i_DC_Data;
                end
                default: ;
            endcase
        end
    end

    assign o_FL_Data_Read = i_MEM_Data_Read  && burst_act && (grant_q == GNT_FL);
    assign o_FL_Valid     = i_MEM_Data_Valid && burst_act && (grant_q == GNT_FL);
    assign o_FL_Last      = i_MEM_Last       && burst_act && (grant_q == GNT_FL);
    assign o_IC_Data_Read = i_MEM_Data_Read  && burst_act && (grant_q == GNT_IC);
    assign o_IC_Valid     = i_MEM_Data_Valid && burst_act && (grant_q == GNT_IC);
    assign o_IC_Last      = i_MEM_Last       && burst_act && (grant_q == GNT_IC);
    assign o_DC_Data_Read = i_MEM_Data_Read  && burst_act && (grant_q == GNT_DC);
    assign o_DC_Valid     = i_MEM_Data_Valid && burst_act && (grant_q == GNT_DC);
    assign o_DC_Last      = i_MEM_Last       && burst_act && (grant_q == GNT_DC);

    assign o_FL_Data = i_MEM_Data;
    assign o_IC_Data = i_MEM_Data;
    assign o_DC_Data = i_MEM_Data;

    assign o_Grant          = grant_q;
    assign o_Grant_Count_IC = CNT_W'(cnt_ic_q);
    assign o_Grant_Count_DC = CNT_W'(cnt_dc_q);

endmodule

// File: tb/tb_sdram_req_scheduler.sv
// Self-checking bench for sdram_req_scheduler. The counter width is narrowed
// to 5 bits so saturation is reached in a few dozen bursts.
module tb_sdram_req_scheduler;

    localparam int DW  = 32;
    localparam int AW  = 22;
    localparam int CW  = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, ld;
    logic fl_v, fl_rw, ic_v, ic_rw, dc_v, dc_rw;
    logic [AW-1:0] fl_a, ic_a, dc_a;
    logic [DW-1:0] fl_wd, ic_wd, dc_wd;
    logic fl_dr, fl_ov, fl_ol, ic_dr, ic_ov, ic_ol, dc_dr, dc_ov, dc_ol;
    logic [DW-1:0] fl_od, ic_od, dc_od;
    logic m_v, m_rw;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    logic mi_dr, mi_dv, mi_last;
    logic [DW-1:0] mi_d;
    logic [1:0] gnt;
    logic [15:0] cnt_ic, cnt_dc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_req_scheduler #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .GRANT_CNT_W(CW)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Load_Done(ld),
        .i_FL_Valid(fl_v), .i_FL_Read_Write_n(fl_rw), .i_FL_Address(fl_a), .i_FL_Data(fl_wd),
        .o_FL_Data_Read(fl_dr), .o_FL_Valid(fl_ov), .o_FL_Last(fl_ol), .o_FL_Data(fl_od),
        .i_IC_Valid(ic_v), .i_IC_Read_Write_n(ic_rw), .i_IC_Address(ic_a), .i_IC_Data(ic_wd),
        .o_IC_Data_Read(ic_dr), .o_IC_Valid(ic_ov), .o_IC_Last(ic_ol), .o_IC_Data(ic_od),
        .i_DC_Valid(dc_v), .i_DC_Read_Write_n(dc_rw), .i_DC_Address(dc_a), .i_DC_Data(dc_wd),
        .o_DC_Data_Read(dc_dr), .o_DC_Valid(dc_ov), .o_DC_Last(dc_ol), .o_DC_Data(dc_od),
        .o_MEM_Valid(m_v), .o_MEM_Read_Write_n(m_rw), .o_MEM_Address(m_a), .o_MEM_Data(m_d),
        .i_MEM_Data_Read(mi_dr), .i_MEM_Data_Valid(mi_dv), .i_MEM_Last(mi_last), .i_MEM_Data(mi_d),
        .o_Grant(gnt), .o_Grant_Count_IC(cnt_ic), .o_Grant_Count_DC(cnt_dc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 none, 1 FL, 2 IC, 3 DC. served_ic: IC was the last of IC/DC served.
    int owner = 0;
    bit served_ic = 0;
    int mc_ic = 0, mc_dc = 0;
    bit m_ok = 0;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; served_ic = 0; mc_ic = 0; mc_dc = 0; m_ok = 1;
        end else if (owner == 0) begin
            int w;
            w = 0;
            if (fl_v) w = 1;
            else if (ld && ic_v && dc_v) w = served_ic ? 3 : 2;
            else if (ld && ic_v) w = 2;
            else if (ld && dc_v) w = 3;
            owner = w;
            if (w == 2) begin served_ic = 1; if (mc_ic < MAXC) mc_ic++; end
            if (w == 3) begin served_ic = 0; if (mc_dc < MAXC) mc_dc++; end
        end else if (mi_last) begin
            owner = 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            logic act;
            logic erw;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            act = (owner != 0) && !rst;
            erw = 0; ea = '0; ed = '0;
            if (act && owner == 1) begin erw = fl_rw; ea = fl_a; ed = fl_wd; end
            if (act && owner == 2) begin erw = ic_rw; ea = ic_a; ed = ic_wd; end
            if (act && owner == 3) begin erw = dc_rw; ea = dc_a; ed = dc_wd; end
            chk("grant", 64'(gnt), 64'(owner));
            chk("mem_valid", 64'(m_v), 64'(act));
            chk("mem_rw", 64'(m_rw), 64'(erw));
            chk("mem_addr", 64'(m_a), 64'(ea));
            chk("mem_data", 64'(m_d), 64'(ed));
            chk("fl_strobes", 64'({fl_dr, fl_ov, fl_ol}), 64'({mi_dr, mi_dv, mi_last} & {3{act && owner == 1}}));
            chk("ic_strobes", 64'({ic_dr, ic_ov, ic_ol}), 64'({mi_dr, mi_dv, mi_last} & {3{act && owner == 2}}));
            chk("dc_strobes", 64'({dc_dr, dc_ov, dc_ol}), 64'({mi_dr, mi_dv, mi_last} & {3{act && owner == 3}}));
            chk("rd_data", 64'({fl_od, ic_od, dc_od}), 64'({mi_d, mi_d, mi_d}));
            chk("cnt_ic", 64'(cnt_ic), 64'(mc_ic));
            chk("cnt_dc", 64'(cnt_dc), 64'(mc_dc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr_mem();
        mi_dr = 0; mi_dv = 0; mi_last = 0;
    endtask

    task automatic wait_grant(output logic [1:0] g);
        int t;
        t = 0;
        while (gnt == 2'd0 && t < 20) begin step(); t++; end
        if (gnt == 2'd0) begin
            n_chk++; n_err++;
            $display("FAIL wait_grant: got timeout expected a grant");
        end
        g = gnt;
    endtask

    // Drives beats starting in the current BURST cycle; last beat carries i_MEM_Last.
    task automatic run_burst(input int beats, input logic rd);
        for (int b = 0; b < beats; b++) begin
            mi_dv = rd; mi_dr = !rd; mi_last = (b == beats - 1); mi_d = $urandom;
            step();
        end
        clr_mem();
    endtask

    task automatic pulse_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd3; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3;

        rst = 1; ld = 0;
        fl_v = 0; fl_rw = 1; fl_a = 22'h0F0000; fl_wd = 32'h1111_0000;
        ic_v = 0; ic_rw = 1; ic_a = 22'h001000; ic_wd = 32'h2222_0000;
        dc_v = 0; dc_rw = 1; dc_a = 22'h002000; dc_wd = 32'h3333_0000;
        clr_mem(); mi_d = '0;
        step(); step();
        chk("reset_grant", 64'(gnt), 64'd0);
        chk("reset_mem_valid", 64'(m_v), 64'd0);
        chk("reset_counts", 64'({cnt_ic, cnt_dc}), 64'd0);
        rst = 0;

        // Load not done: FL wins over IC; IC waits until load done.
        fl_v = 1; ic_v = 1; step();
        chk("fl_first", 64'(gnt), 64'd1);
        fl_v = 0;
        run_burst(2, 1);
        chk("idle_after_fl", 64'(gnt), 64'd0);
        step(); step();
        chk("ic_blocked_no_load", 64'(gnt), 64'd0);
        ld = 1; step();
        chk("ic_after_load", 64'(gnt), 64'd2);
        ic_v = 0;
        run_burst(3, 1);

        // i_MEM_Last while idle does nothing.
        mi_last = 1; step(); clr_mem();
        chk("idle_last_ignored", 64'(gnt), 64'd0);

        // Round robin on continuous IC+DC ties.
        pulse_reset();
        ic_v = 1; dc_v = 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk("rr_seq", 64'(g), 64'(exp_seq[k]));
            run_burst(4, 1);
        end
        ic_v = 0; dc_v = 0;
        chk("rr_counts", 64'({cnt_ic, cnt_dc}), {32'd0, 16'd2, 16'd2});
        step();

        // DC write burst.
        dc_v = 1; dc_rw = 0; dc_a = 22'h000100; dc_wd = 32'hA5A5_0001;
        wait_grant(g);
        chk("dc_wr_grant", 64'(g), 64'd3);
        chk("dc_wr_addr", 64'(m_a), 64'h100);
        chk("dc_wr_rw", 64'(m_rw), 64'd0);
        chk("dc_wr_data", 64'(m_d), 64'hA5A5_0001);
        dc_v = 0;
        mi_dr = 1; #1;
        chk("dc_data_read", 64'({dc_dr, ic_dr}), 64'b10);
        step();
        mi_dr = 0; #1;
        chk("dc_data_read_low", 64'(dc_dr), 64'd0);
        mi_dr = 1; mi_last = 1; step(); clr_mem();
        dc_rw = 1;

        // FL arrives mid IC burst: no preemption, one idle cycle, then FL.
        ic_v = 1; wait_grant(g);
        chk("ic_before_fl", 64'(g), 64'd2);
        mi_dv = 1; step();
        fl_v = 1; ic_v = 0;
        mi_dv = 1; step();
        chk("ic_not_preempted", 64'(gnt), 64'd2);
        mi_dv = 1; mi_last = 1; step(); clr_mem();
        chk("gap_idle", 64'(gnt), 64'd0);
        step();
        chk("fl_after_gap", 64'(gnt), 64'd1);
        fl_v = 0;
        run_burst(2, 1);

        // Reset during beat 2 of a DC burst.
        dc_v = 1; wait_grant(g);
        chk("dc_before_reset", 64'(g), 64'd3);
        mi_dv = 1; step();
        rst = 1; mi_dv = 1; #1;
        chk("strobe_masked_in_reset", 64'({dc_ov, m_v}), 64'd0);
        step(); rst = 0; clr_mem();
        chk("post_reset_grant", 64'(gnt), 64'd0);
        chk("post_reset_mem_valid", 64'(m_v), 64'd0);
        chk("post_reset_counts", 64'({cnt_ic, cnt_dc}), 64'd0);
        ic_v = 1; dc_v = 1;
        wait_grant(g);
        chk("post_reset_tie", 64'(g), 64'd2);
        ic_v = 0; dc_v = 0;
        run_burst(1, 1);

        // Saturation of the IC counter.
        pulse_reset();
        ic_v = 1;
        for (int k = 0; k < MAXC + 9; k++) begin
            wait_grant(g);
            run_burst(1, 1);
        end
        ic_v = 0;
        step();
        chk("ic_saturated", 64'(cnt_ic), 64'(MAXC));
        chk("dc_untouched", 64'(cnt_dc), 64'd0);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
